// File: rtl/fflags_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fflags_queue_pkg
// Description : Shared sizes, types and pointer helper for the fflags ROB
//               index queue.
//               DEPTH  - number of queue entries (any value >= 2)
//               ADDR_W - RAM address width, ceil(log2(DEPTH))
//               DATA_W - ROB index width stored per entry
// Revision    : 1.0 - initial release
// ============================================================================
package fflags_queue_pkg;

  localparam int DEPTH  = 3;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 7;

  typedef logic [DATA_W-1:0] rob_idx_t;
  typedef logic [ADDR_W-1:0] qptr_t;

  localparam qptr_t PTR_LAST = qptr_t'(DEPTH - 1);

  // Explicit wrap at DEPTH-1: DEPTH need not be a power of two, so the
  // pointer must never be allowed to roll over naturally.
  function automatic qptr_t wrap_inc(input qptr_t ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + qptr_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fflags_wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fflags_wrap_ptr
// Description : Queue pointer register with wrap at DEPTH-1.
//   clk_i  in  clock
//   rst_i  in  synchronous active-high reset, pointer -> 0
//   clr_i  in  clear (flush), pointer -> 0, wins over inc_i
//   inc_i  in  advance pointer by one with wrap
//   ptr_o  out current pointer value
// Revision    : 1.0 - initial release
// ============================================================================
module fflags_wrap_ptr
  import fflags_queue_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clr_i,
  input  logic  inc_i,
  output qptr_t ptr_o
);

  qptr_t ptr_q;
  qptr_t ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = wrap_inc(ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fflags_rob_idx_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fflags_rob_idx_queue_ctrl
// Description : FIFO controller for the fflags ROB index queue. Runs an
//               external DEPTH-entry 1R1W flop RAM (combinational read,
//               synchronous write) and owns pointers, full/empty and flush.
//   clock, reset          clock and synchronous active-high reset
//   io_enq_valid/ready/bits  push side (FP execution pipe)
//   io_deq_valid/ready/bits  pop side (ROB fflags update)
//   io_flush              discard all entries, highest priority
//   io_count              number of valid entries, 0..DEPTH
//   ram_W0_*              RAM write port (addr = enq pointer)
//   ram_R0_*              RAM read port (addr = deq pointer)
// Parameter   : PIPE - accept an enqueue while full if a dequeue fires
// Revision    : 1.0 - initial release
// ============================================================================
module fflags_rob_idx_queue_ctrl
  import fflags_queue_pkg::*;
#(
  parameter bit PIPE = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_enq_valid,
  output logic              io_enq_ready,
  input  logic [DATA_W-1:0] io_enq_bits,
  output logic              io_deq_valid,
  input  logic              io_deq_ready,
  output logic [DATA_W-1:0] io_deq_bits,
  input  logic              io_flush,
  output logic [ADDR_W:0]   io_count,
  output logic [ADDR_W-1:0] ram_W0_addr,
  output logic              ram_W0_en,
  output logic [DATA_W-1:0] ram_W0_data,
  output logic [ADDR_W-1:0] ram_R0_addr,
  output logic              ram_R0_en,
  input  logic [DATA_W-1:0] ram_R0_data
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  qptr_t enq_ptr;
  qptr_t deq_ptr;
  logic  maybe_full_q;
  logic  maybe_full_d;

  logic  ptr_match;
  logic  empty;
  logic  full;
  logic  do_enq;
  logic  do_deq;
  logic  kill;

  logic [ADDR_W:0] enq_ext;
  logic [ADDR_W:0] deq_ext;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match &  maybe_full_q;

  assign io_deq_valid = ~empty;
  assign io_enq_ready = ~full | (PIPE & io_deq_ready);

  // Reset behaves like a flush: nothing fires and the RAM is not written.
  assign kill   = io_flush | reset;
  assign do_enq = io_enq_valid & io_enq_ready & ~kill;
  assign do_deq = io_deq_valid & io_deq_ready & ~kill;

  fflags_wrap_ptr u_enq_ptr (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (io_flush),
    .inc_i (do_enq),
    .ptr_o (enq_ptr)
  );

  fflags_wrap_ptr u_deq_ptr (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (io_flush),
    .inc_i (do_deq),
    .ptr_o (deq_ptr)
  );

  // maybe_full distinguishes full from empty when the pointers coincide;
  // only an unbalanced cycle can change which of the two we are in.
  always_comb begin
    maybe_full_d = maybe_full_q;
    if (io_flush) begin
      maybe_full_d = 1'b0;
    end else if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      maybe_full_q <= 1'b0;
    end else begin
      maybe_full_q <= maybe_full_d;
    end
  end

  // Occupancy with explicit wrap correction for non-power-of-two depth.
  assign enq_ext = {1'b0, enq_ptr};
  assign deq_ext = {1'b0, deq_ptr};

  always_comb begin
    io_count = '0;
    if (full) begin
      io_count = DEPTH_CNT;
    end else if (enq_ext >= deq_ext) begin
      io_count = enq_ext - deq_ext;
    end else begin
      io_count = DEPTH_CNT + enq_ext - deq_ext;
    end
  end

  assign ram_W0_addr = enq_ptr;
  assign ram_W0_en   = do_enq;
  assign ram_W0_data = io_enq_bits;
  assign ram_R0_addr = deq_ptr;
  assign ram_R0_en   = 1'b1;
  assign io_deq_bits = ram_R0_data;

endmodule
`default_nettype wire

// File: tb/tb_fflags_rob_idx_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fflags_rob_idx_queue_ctrl
// Description : Self-checking bench. Two controller instances (PIPE=0 and
//               PIPE=1) share stimulus; each drives its own RAM model and is
//               compared against its own queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fflags_rob_idx_queue_ctrl;

  localparam int DEPTH = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       enq_valid;
  logic [6:0] enq_bits;
  logic       deq_ready;
  logic       flush;

  logic       enq_ready [2];
  logic       deq_valid [2];
  logic [6:0] deq_bits  [2];
  logic [2:0] count     [2];
  logic [1:0] w_addr    [2];
  logic       w_en      [2];
  logic [6:0] w_data    [2];
  logic [1:0] r_addr    [2];
  logic       r_en      [2];
  logic [6:0] r_data    [2];

  logic [6:0] mem0 [4];
  logic [6:0] mem1 [4];

  int checks = 0;
  int errors = 0;

  // Reference state: contents in order, plus counts of pushes/pops since
  // the last reset or flush (addresses are those counts modulo DEPTH).
  logic [6:0] mq [2][$];
  int n_enq [2];
  int n_deq [2];

  always #5 clock = ~clock;

  fflags_rob_idx_queue_ctrl #(.PIPE(1'b0)) u_dut0 (
    .clock        (clock),
    .reset        (reset),
    .io_enq_valid (enq_valid),
    .io_enq_ready (enq_ready[0]),
    .io_enq_bits  (enq_bits),
    .io_deq_valid (deq_valid[0]),
    .io_deq_ready (deq_ready),
    .io_deq_bits  (deq_bits[0]),
    .io_flush     (flush),
    .io_count     (count[0]),
    .ram_W0_addr  (w_addr[0]),
    .ram_W0_en    (w_en[0]),
    .ram_W0_data  (w_data[0]),
    .ram_R0_addr  (r_addr[0]),
    .ram_R0_en    (r_en[0]),
    .ram_R0_data  (r_data[0])
  );

  fflags_rob_idx_queue_ctrl #(.PIPE(1'b1)) u_dut1 (
    .clock        (clock),
    .reset        (reset),
    .io_enq_valid (enq_valid),
    .io_enq_ready (enq_ready[1]),
    .io_enq_bits  (enq_bits),
    .io_deq_valid (deq_valid[1]),
    .io_deq_ready (deq_ready),
    .io_deq_bits  (deq_bits[1]),
    .io_flush     (flush),
    .io_count     (count[1]),
    .ram_W0_addr  (w_addr[1]),
    .ram_W0_en    (w_en[1]),
    .ram_W0_data  (w_data[1]),
    .ram_R0_addr  (r_addr[1]),
    .ram_R0_en    (r_en[1]),
    .ram_R0_data  (r_data[1])
  );

  always @(posedge clock) begin
    if (w_en[0]) mem0[w_addr[0]] <= w_data[0];
    if (w_en[1]) mem1[w_addr[1]] <= w_data[1];
  end
  assign r_data[0] = mem0[r_addr[0]];
  assign r_data[1] = mem1[r_addr[1]];

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
  task automatic step(input logic rst, input logic ev, input logic [6:0] eb,
                      input logic dr, input logic fl);
    logic e_enq [2];
    logic e_deq [2];
    @(negedge clock);
    reset     = rst;
    enq_valid = ev;
    enq_bits  = eb;
    deq_ready = dr;
    flush     = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      int  sz;
      logic e_rdy;
      sz     = mq[k].size();
      e_rdy  = (sz < DEPTH) || ((k == 1) && dr);
      e_enq[k] = ev && e_rdy && !fl && !rst;
      e_deq[k] = (sz != 0) && dr && !fl && !rst;
      chk("deq_valid", k, deq_valid[k], (sz != 0));
      chk("enq_ready", k, enq_ready[k], e_rdy);
      chk("count",     k, count[k], sz);
      chk("w_en",      k, w_en[k], e_enq[k]);
      chk("w_addr",    k, w_addr[k], n_enq[k] % DEPTH);
      chk("w_data",    k, w_data[k], eb);
      chk("r_addr",    k, r_addr[k], n_deq[k] % DEPTH);
      chk("r_en",      k, r_en[k], 1'b1);
      if (sz != 0) chk("deq_bits", k, deq_bits[k], mq[k][0]);
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (rst || fl) begin
        mq[k].delete();
        n_enq[k] = 0;
        n_deq[k] = 0;
      end else begin
        if (e_deq[k]) begin
          void'(mq[k].pop_front());
          n_deq[k]++;
        end
        if (e_enq[k]) begin
          mq[k].push_back(eb);
          n_enq[k]++;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_enq[k] = 0;
      n_deq[k] = 0;
    end
    reset = 1'b1; enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b0; flush = 1'b0;
    @(posedge clock);
    @(posedge clock);

    // Reset state, then fill with three entries.
    step(1'b1, 1'b1, 7'h33, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h05, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h12, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h7F, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h44, 1'b0, 1'b0);   // full: push refused

    // Drain in order, one extra cycle to see empty.
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);

    // Refill, then push+pop while full (PIPE differs between instances).
    step(1'b0, 1'b1, 7'h21, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h23, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h24, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);

    // Mid-operation reset while draining.
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);

    // Flush with two entries and a push pending.
    step(1'b0, 1'b1, 7'h31, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h32, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h33, 1'b0, 1'b1);
    step(1'b0, 1'b1, 7'h34, 1'b0, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 100; i++) begin
      step(1'b0,
           ($urandom_range(0, 99) < 60),
           7'($urandom),
           ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
